// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and framebuffer geometry for the VGA path.
// Used by the scan controller, the colouring stage and the framebuffer.
package vga_timing_pkg;

    localparam int DefHVisible = 640;
    localparam int DefHFront   = 16;
    localparam int DefHSync    = 96;
    localparam int DefHBack    = 48;
    localparam int DefVVisible = 480;
    localparam int DefVFront   = 10;
    localparam int DefVSync    = 2;
    localparam int DefVBack    = 33;

    localparam int DefScreenX  = 320;
    localparam int DefScreenY  = 240;
    localparam int DefAddrBits = 17;

    typedef logic [9:0] coord_t;

    function automatic int h_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

    function automatic int v_total(int visible, int front, int sync, int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// Raster position, sync and framebuffer address bundle leaving the scan controller.
interface vga_scan_controller_if
    import vga_timing_pkg::*;
#(
    parameter int AddrBits = DefAddrBits
);
    coord_t                posicionX;
    coord_t                posicionY;
    logic                  hsync;
    logic                  vsync;
    logic                  videoOn;
    logic [AddrBits-1:0]   addressMemory;
    logic                  pixelTick;
    logic                  frameStart;

    modport master (
        output posicionX, posicionY, hsync, vsync, videoOn,
               addressMemory, pixelTick, frameStart
    );

    modport slave (
        input  posicionX, posicionY, hsync, vsync, videoOn,
               addressMemory, pixelTick, frameStart
    );
endinterface

// File: rtl/pixel_tick_gen.sv
// Clock-enable divider: one-clock pixelTick strobe every ClockDivide system clocks.
module pixel_tick_gen #(
    parameter int ClockDivide = 2
) (
    input  logic clock,
    input  logic reset,
    output logic pixelTick
);
    localparam int DivW = (ClockDivide > 1) ? $clog2(ClockDivide) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(ClockDivide - 1);
    localparam logic [DivW-1:0] DivOne  = DivW'(1);

    logic [DivW-1:0] div;

    // The strobe is registered from the divider value, so it lands one clock
    // after the divider reaches its last count.
    always_ff @(posedge clock) begin
        if (reset) begin
            div       <= '0;
            pixelTick <= 1'b0;
        end else begin
            div       <= (div == DivLast) ? '0 : div + DivOne;
            pixelTick <= (div == DivLast);
        end
    end
endmodule

// File: rtl/vga_scan_controller.sv
// Raster timing generator: pixel-rate X/Y counters, sync decode and a
// multiplier-free framebuffer address for the colouring stage.
module vga_scan_controller
    import vga_timing_pkg::*;
#(
    parameter int ClockDivide = 2,
    parameter int HVisible    = DefHVisible,
    parameter int HFront      = DefHFront,
    parameter int HSync       = DefHSync,
    parameter int HBack       = DefHBack,
    parameter int VVisible    = DefVVisible,
    parameter int VFront      = DefVFront,
    parameter int VSync       = DefVSync,
    parameter int VBack       = DefVBack,
    parameter int screenX     = DefScreenX,
    parameter int screenY     = DefScreenY,
    parameter int AddrBits    = DefAddrBits
) (
    input  logic                   clock,
    input  logic                   reset,
    vga_scan_controller_if.master  vga
);
    localparam int HTotal = h_total(HVisible, HFront, HSync, HBack);
    localparam int VTotal = v_total(VVisible, VFront, VSync, VBack);

    localparam coord_t HLast      = coord_t'(HTotal - 1);
    localparam coord_t VLast      = coord_t'(VTotal - 1);
    localparam coord_t HVis       = coord_t'(HVisible);
    localparam coord_t VVis       = coord_t'(VVisible);
    localparam coord_t HSyncStart = coord_t'(HVisible + HFront);
    localparam coord_t HSyncEnd   = coord_t'(HVisible + HFront + HSync);
    localparam coord_t VSyncStart = coord_t'(VVisible + VFront);
    localparam coord_t VSyncEnd   = coord_t'(VVisible + VFront + VSync);
    localparam coord_t ScreenXC   = coord_t'(screenX);
    localparam coord_t ScreenYC   = coord_t'(screenY);
    localparam coord_t CoordOne   = coord_t'(1);
    localparam logic [AddrBits-1:0] RowStep = AddrBits'(screenX);

    logic                tick;
    coord_t              x, y, x_n, y_n;
    logic [AddrBits-1:0] rowBase, rowBase_n;
    logic                lineEnd, frameEnd;
    logic                hsync_r, vsync_r, videoOn_r, frameStart_r;
    logic [AddrBits-1:0] addr_r;

    pixel_tick_gen #(
        .ClockDivide (ClockDivide)
    ) u_pixel_tick (
        .clock     (clock),
        .reset     (reset),
        .pixelTick (tick)
    );

    // rowBase tracks Y*screenX incrementally so the address needs only an adder.
    always_comb begin
        x_n       = x;
        y_n       = y;
        rowBase_n = rowBase;
        lineEnd   = (x == HLast);
        frameEnd  = lineEnd && (y == VLast);
        if (tick) begin
            if (lineEnd) begin
                x_n = '0;
                if (frameEnd) begin
                    y_n       = '0;
                    rowBase_n = '0;
                end else begin
                    y_n = y + CoordOne;
                    if (y < ScreenYC) begin
                        rowBase_n = rowBase + RowStep;
                    end
                end
            end else begin
                x_n = x + CoordOne;
            end
        end
    end

    // Decoded outputs are computed from the next position so every output
    // register describes the same (X,Y) as the counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            x            <= '0;
            y            <= '0;
            rowBase      <= '0;
            hsync_r      <= 1'b1;
            vsync_r      <= 1'b1;
            videoOn_r    <= 1'b0;
            addr_r       <= '0;
            frameStart_r <= 1'b0;
        end else begin
            x            <= x_n;
            y            <= y_n;
            rowBase      <= rowBase_n;
            hsync_r      <= !((x_n >= HSyncStart) && (x_n < HSyncEnd));
            vsync_r      <= !((y_n >= VSyncStart) && (y_n < VSyncEnd));
            videoOn_r    <= (x_n < HVis) && (y_n < VVis);
            addr_r       <= ((x_n < ScreenXC) && (y_n < ScreenYC))
                            ? rowBase_n + AddrBits'(x_n) : '0;
            frameStart_r <= tick && frameEnd;
        end
    end

    assign vga.posicionX     = x;
    assign vga.posicionY     = y;
    assign vga.hsync         = hsync_r;
    assign vga.vsync         = vsync_r;
    assign vga.videoOn       = videoOn_r;
    assign vga.addressMemory = addr_r;
    assign vga.pixelTick     = tick;
    assign vga.frameStart    = frameStart_r;
endmodule
